pipeline_memd_stage7: RTL

Memory-data stage of the 7-stage RV64 pipeline, directly downstream of the memory-prepare stage. It waits for the selected target (DRAM or system bus) to acknowledge the access prepared in the previous cycle, stalling the front of the pipeline while the target is busy. It then extracts and extends load data according to the load type and registers the result, together with the write-back control, for the WB stage. It also detects misaligned accesses and bus timeouts.

---
 rtl/pipeline_memd_stage7.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/pipeline_memd_stage7.sv
// Memory-data stage: waits for the DRAM/system-bus acknowledge, extracts and extends
// load data, flags misaligned accesses and timeouts, and registers results for WB.
module pipeline_memd_stage7 #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        is_dram_MEMP,
  input  logic [63:0] pc_MEMP,
  input  logic [1:0]  rf_wr_sel_MEMP,
  input  logic        rf_wr_en_MEMP,
  input  logic [63:0] alu_result_MEMP,
  input  logic [4:0]  rd_MEMP,
  input  logic [2:0]  mem_rd_ctrl_MEMP,
  input  logic [2:0]  mem_wr_ctrl_MEMP,
  input  logic [63:0] dram_dout,
  input  logic        dram_ready,
  input  logic [63:0] sys_bus_dout,
  input  logic        sys_bus_ready,
  output logic        stall_req,
  output logic [63:0] pc_MEMD,
  output logic [1:0]  rf_wr_sel_MEMD,
  output logic        rf_wr_en_MEMD,
  output logic [63:0] alu_result_MEMD,
  output logic [4:0]  rd_MEMD,
  output logic [63:0] mem_data_MEMD,
  output logic [1:0]  mem_err_MEMD
);

  localparam int unsigned CNT_W = 8;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [63:0] pc_d, alu_result_d, mem_data_d;
  logic [1:0]  rf_wr_sel_d, mem_err_d;
  logic        rf_wr_en_d;
  logic [4:0]  rd_d;

  logic [2:0]  addr_lo;
  logic        misaligned, access, ready, at_limit, timeout, stall_req_int;
  logic [63:0] dout, load_data;

  // Shared width code: 1/2 byte, 3/4 half, 5/6 word, 7 doubleword.
  function automatic logic misaligned_f(input logic [2:0] code, input logic [2:0] a);
    logic m;
    case (code)
      3'd3, 3'd4: m = a[0];
      3'd5, 3'd6: m = |a[1:0];
      3'd7:       m = |a;
      default:    m = 1'b0;
    endcase
    return m;
  endfunction

  // Lane select from the aligned doubleword, then sign/zero extend.
  function automatic logic [63:0] load_ext(input logic [2:0] code, input logic [2:0] a,
                                           input logic [63:0] d);
    logic [63:0] sb, sh, sw, r;
    sb = d >> {a, 3'b000};
    sh = d >> {a[2:1], 4'b0000};
    sw = d >> {a[2], 5'b00000};
    case (code)
      3'd1:    r = {{56{sb[7]}}, sb[7:0]};
      3'd2:    r = {56'd0, sb[7:0]};
      3'd3:    r = {{48{sh[15]}}, sh[15:0]};
      3'd4:    r = {48'd0, sh[15:0]};
      3'd5:    r = {{32{sw[31]}}, sw[31:0]};
      3'd6:    r = {32'd0, sw[31:0]};
      3'd7:    r = d;
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  always_comb begin
    addr_lo    = alu_result_MEMP[2:0];
    misaligned = misaligned_f(mem_rd_ctrl_MEMP, addr_lo) | misaligned_f(mem_wr_ctrl_MEMP, addr_lo);
    access     = (|(mem_rd_ctrl_MEMP | mem_wr_ctrl_MEMP)) & ~misaligned;
    ready      = is_dram_MEMP ? dram_ready : sys_bus_ready;
    dout       = is_dram_MEMP ? dram_dout : sys_bus_dout;
    load_data  = load_ext(mem_rd_ctrl_MEMP, addr_lo, dout);
    at_limit   = (state_q == WAIT) && (cnt_q == CNT_W'(TIMEOUT));
    timeout    = access & ~ready & at_limit;
    stall_req_int = access & ~ready & ~at_limit;
  end

  // Held low during reset so the front end is not frozen by stale MEMP inputs.
  assign stall_req = reset & stall_req_int;

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_d         = pc_MEMD;
    rf_wr_sel_d  = rf_wr_sel_MEMD;
    rf_wr_en_d   = rf_wr_en_MEMD;
    alu_result_d = alu_result_MEMD;
    rd_d         = rd_MEMD;
    mem_data_d   = mem_data_MEMD;
    mem_err_d    = mem_err_MEMD;
    if (!stall) begin
      if (stall_req_int) begin
        rf_wr_en_d = 1'b0;
        mem_err_d  = ERR_NONE;
        if (state_q == IDLE) begin
          state_d = WAIT;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        state_d      = IDLE;
        cnt_d        = '0;
        pc_d         = pc_MEMP;
        rf_wr_sel_d  = rf_wr_sel_MEMP;
        alu_result_d = alu_result_MEMP;
        rd_d         = rd_MEMP;
        rf_wr_en_d   = rf_wr_en_MEMP & ~misaligned & ~timeout;
        mem_data_d   = (misaligned | timeout) ? 64'd0 : load_data;
        if (misaligned)   mem_err_d = ERR_MISALIGN;
        else if (timeout) mem_err_d = ERR_TIMEOUT;
        else              mem_err_d = ERR_NONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      pc_MEMD         <= '0;
      rf_wr_sel_MEMD  <= '0;
      rf_wr_en_MEMD   <= 1'b0;
      alu_result_MEMD <= '0;
      rd_MEMD         <= '0;
      mem_data_MEMD   <= '0;
      mem_err_MEMD    <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      pc_MEMD         <= pc_d;
      rf_wr_sel_MEMD  <= rf_wr_sel_d;
      rf_wr_en_MEMD   <= rf_wr_en_d;
      alu_result_MEMD <= alu_result_d;
      rd_MEMD         <= rd_d;
      mem_data_MEMD   <= mem_data_d;
      mem_err_MEMD    <= mem_err_d;
    end
  end

endmodule
